// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads opcode/operand bytes from the program ROM and hands whole
// instructions to the decoder over valid/ready. Optional IFETCH_SKIP_NOP_EN drops NOP (8'h00) opcodes.
module instr_fetch #(
  parameter logic [7:0] RESET_PC   = 8'h00,
  parameter logic [3:0] HLT_NIBBLE = 4'hF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [7:0] rom_addr_o,
  output logic       rom_read_o,
  output logic       rom_ena_o,
  input  logic [7:0] rom_data_i,
  output logic       ins_valid_o,
  input  logic       ins_ready_i,
  output logic [7:0] ins_opcode_o,
  output logic [7:0] ins_operand_o,
  output logic       ins_two_byte_o,
  output logic [7:0] ins_pc_o,
  input  logic       jmp_req_i,
  input  logic [7:0] jmp_addr_i,
  output logic       halted_o
);

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_ARG = 2'd1,
    HOLD      = 2'd2,
    HALT      = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] operand_q, operand_d;
  logic [7:0] insPc_q, insPc_d;
  logic       twoByte_q, twoByte_d;
  logic       fetchEn;
  logic       opIsTwoByte;
  logic       skipNop;

  always_comb begin
    case (rom_data_i[7:4])
      4'h1, 4'h2, 4'h3, 4'hA: opIsTwoByte = 1'b1;
      default:                opIsTwoByte = 1'b0;
    endcase
  end

`ifdef IFETCH_SKIP_NOP_EN
  assign skipNop = (rom_data_i == 8'h00);
`else
  assign skipNop = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    insPc_d   = insPc_q;
    twoByte_d = twoByte_q;
    fetchEn   = (state_q == FETCH_OP) || (state_q == FETCH_ARG);

    // A jump wins over everything; any partially fetched instruction is simply abandoned.
    if (jmp_req_i) begin
      pc_d    = jmp_addr_i;
      state_d = FETCH_OP;
    end else begin
      case (state_q)
        FETCH_OP: begin
          pc_d = pc_q + 8'd1;
          if (!skipNop) begin
            opcode_d  = rom_data_i;
            insPc_d   = pc_q;
            twoByte_d = opIsTwoByte;
            if (opIsTwoByte) begin
              state_d = FETCH_ARG;
            end else begin
              operand_d = 8'h00;
              state_d   = HOLD;
            end
          end
        end
        FETCH_ARG: begin
          operand_d = rom_data_i;
          pc_d      = pc_q + 8'd1;
          state_d   = HOLD;
        end
        HOLD: begin
          if (ins_ready_i) begin
            state_d = (opcode_q[7:4] == HLT_NIBBLE) ? HALT : FETCH_OP;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = FETCH_OP;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= FETCH_OP;
      pc_q      <= RESET_PC;
      opcode_q  <= 8'h00;
      operand_q <= 8'h00;
      insPc_q   <= 8'h00;
      twoByte_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      insPc_q   <= insPc_d;
      twoByte_q <= twoByte_d;
    end
  end

  assign rom_addr_o     = pc_q;
  assign rom_read_o     = fetchEn;
  assign rom_ena_o      = fetchEn;
  assign ins_valid_o    = (state_q == HOLD);
  assign halted_o       = (state_q == HALT);
  assign ins_opcode_o   = opcode_q;
  assign ins_operand_o  = operand_q;
  assign ins_two_byte_o = twoByte_q;
  assign ins_pc_o       = insPc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: a default-reset unit runs the main program image and a
// second unit with RESET_PC=8'hFF covers PC wrap and reset during an operand fetch.
module tb_instr_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, insReady, jmpReq;
  logic [7:0] jmpAddr;
  logic [7:0] romAddr, romData, insOpcode, insOperand, insPc;
  logic       romRead, romEna, insValid, insTwoByte, halted;

  logic       rst1, insReady1, jmpReq1;
  logic [7:0] jmpAddr1;
  logic [7:0] romAddr1, romData1, insOpcode1, insOperand1, insPc1;
  logic       romRead1, romEna1, insValid1, insTwoByte1, halted1;

  logic [7:0] mem [0:255];

  int passCount  = 0;
  int checkCount = 0;

  assign romData  = (romRead && romEna) ? mem[romAddr] : 8'hzz;
  assign romData1 = (romRead1 && romEna1) ? mem[romAddr1] : 8'hzz;

  instr_fetch dut (
    .clk_i(clk), .rst_i(rst),
    .rom_addr_o(romAddr), .rom_read_o(romRead), .rom_ena_o(romEna), .rom_data_i(romData),
    .ins_valid_o(insValid), .ins_ready_i(insReady), .ins_opcode_o(insOpcode),
    .ins_operand_o(insOperand), .ins_two_byte_o(insTwoByte), .ins_pc_o(insPc),
    .jmp_req_i(jmpReq), .jmp_addr_i(jmpAddr), .halted_o(halted)
  );

  instr_fetch #(.RESET_PC(8'hFF), .HLT_NIBBLE(4'hF)) dutWrap (
    .clk_i(clk), .rst_i(rst1),
    .rom_addr_o(romAddr1), .rom_read_o(romRead1), .rom_ena_o(romEna1), .rom_data_i(romData1),
    .ins_valid_o(insValid1), .ins_ready_i(insReady1), .ins_opcode_o(insOpcode1),
    .ins_operand_o(insOperand1), .ins_two_byte_o(insTwoByte1), .ins_pc_o(insPc1),
    .jmp_req_i(jmpReq1), .jmp_addr_i(jmpAddr1), .halted_o(halted1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; insReady = 1'b1; jmpReq = 1'b0; jmpAddr = 8'h00;
    step(); step();
    checkCount++;
    if (insValid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", insValid); else passCount++;
    checkCount++;
    if (halted !== 1'b0) $display("[TB] FAIL reset_halted: got %b expected 0", halted); else passCount++;
    checkCount++;
    if ({insOpcode, insOperand, insPc, insTwoByte} !== 25'd0)
      $display("[TB] FAIL reset_ins: got %h/%h/%h/%b expected all zero", insOpcode, insOperand, insPc, insTwoByte);
    else passCount++;
    checkCount++;
    if (romAddr !== 8'h00 || romEna !== 1'b1)
      $display("[TB] FAIL reset_rom: got addr %h ena %b expected addr 00 ena 1", romAddr, romEna);
    else passCount++;
  endtask

  task automatic test_first_fetch();
    rst = 1'b0;
`ifdef IFETCH_SKIP_NOP_EN
    step();
    checkCount++;
    if (insValid !== 1'b0 || romAddr !== 8'h01)
      $display("[TB] FAIL nop_skip: got valid %b addr %h expected valid 0 addr 01", insValid, romAddr);
    else passCount++;
`else
    step();
    checkCount++;
    if (insValid !== 1'b1 || insOpcode !== 8'h00 || insPc !== 8'h00 || insTwoByte !== 1'b0 || insOperand !== 8'h00)
      $display("[TB] FAIL first_nop: got v%b op %h pc %h tb %b arg %h expected v1 op 00 pc 00 tb 0 arg 00",
               insValid, insOpcode, insPc, insTwoByte, insOperand);
    else passCount++;
    step();
    checkCount++;
    if (insValid !== 1'b0 || romAddr !== 8'h01 || romEna !== 1'b1)
      $display("[TB] FAIL after_nop: got v%b addr %h ena %b expected v0 addr 01 ena 1", insValid, romAddr, romEna);
    else passCount++;
`endif
    step();
    checkCount++;
    if (insValid !== 1'b0 || romAddr !== 8'h02)
      $display("[TB] FAIL fetch_arg: got v%b addr %h expected v0 addr 02", insValid, romAddr);
    else passCount++;
    step();
    checkCount++;
    if (insValid !== 1'b1 || insOpcode !== 8'h11 || insOperand !== 8'h81 || insTwoByte !== 1'b1 || insPc !== 8'h01)
      $display("[TB] FAIL ldo_present: got v%b op %h arg %h tb %b pc %h expected v1 op 11 arg 81 tb 1 pc 01",
               insValid, insOpcode, insOperand, insTwoByte, insPc);
    else passCount++;
  endtask

  task automatic test_hold();
    insReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checkCount++;
      if (insValid !== 1'b1 || insOpcode !== 8'h11 || insOperand !== 8'h81 || insPc !== 8'h01 ||
          romEna !== 1'b0 || romRead !== 1'b0 || romAddr !== 8'h03)
        $display("[TB] FAIL hold_stable[%0d]: got v%b op %h arg %h pc %h ena %b addr %h expected v1 op 11 arg 81 pc 01 ena 0 addr 03",
                 i, insValid, insOpcode, insOperand, insPc, romEna, romAddr);
      else passCount++;
    end
    insReady = 1'b1;
    step();
    checkCount++;
    if (insValid !== 1'b0 || romAddr !== 8'h03 || romEna !== 1'b1)
      $display("[TB] FAIL hold_release: got v%b addr %h ena %b expected v0 addr 03 ena 1", insValid, romAddr, romEna);
    else passCount++;
  endtask

  task automatic test_jump();
    jmpReq = 1'b1; jmpAddr = 8'h09;
    step();
    jmpReq = 1'b0;
    checkCount++;
    if (romAddr !== 8'h09 || insValid !== 1'b0)
      $display("[TB] FAIL jmp_to_09: got addr %h v%b expected addr 09 v0", romAddr, insValid);
    else passCount++;
    step(); step();
    checkCount++;
    if (insValid !== 1'b1 || insOpcode !== 8'hA3 || insOperand !== 8'h0F || insPc !== 8'h09 || insTwoByte !== 1'b1)
      $display("[TB] FAIL jmp_present: got v%b op %h arg %h pc %h tb %b expected v1 op A3 arg 0F pc 09 tb 1",
               insValid, insOpcode, insOperand, insPc, insTwoByte);
    else passCount++;
    jmpReq = 1'b1; jmpAddr = 8'h0F;
    step();
    jmpReq = 1'b0;
    checkCount++;
    if (romAddr !== 8'h0F || insValid !== 1'b0 || romEna !== 1'b1)
      $display("[TB] FAIL jmp_accept: got addr %h v%b ena %b expected addr 0F v0 ena 1", romAddr, insValid, romEna);
    else passCount++;
    step();
    checkCount++;
    if (insValid !== 1'b1 || insOpcode !== 8'hB0 || insPc !== 8'h0F || insTwoByte !== 1'b0 || insOperand !== 8'h00)
      $display("[TB] FAIL after_jmp: got v%b op %h pc %h tb %b arg %h expected v1 op B0 pc 0F tb 0 arg 00",
               insValid, insOpcode, insPc, insTwoByte, insOperand);
    else passCount++;
  endtask

  task automatic test_halt();
    jmpReq = 1'b1; jmpAddr = 8'h0E;
    step();
    jmpReq = 1'b0;
    checkCount++;
    if (romAddr !== 8'h0E) $display("[TB] FAIL jmp_to_0E: got %h expected 0E", romAddr); else passCount++;
    step();
    checkCount++;
    if (insValid !== 1'b1 || insOpcode !== 8'hF0 || insPc !== 8'h0E)
      $display("[TB] FAIL hlt_present: got v%b op %h pc %h expected v1 op F0 pc 0E", insValid, insOpcode, insPc);
    else passCount++;
    for (int i = 0; i < 11; i++) begin
      step();
      checkCount++;
      if (halted !== 1'b1 || insValid !== 1'b0 || romEna !== 1'b0 || romRead !== 1'b0 || romAddr !== 8'h0F)
        $display("[TB] FAIL halted[%0d]: got h%b v%b ena %b rd %b addr %h expected h1 v0 ena 0 rd 0 addr 0F",
                 i, halted, insValid, romEna, romRead, romAddr);
      else passCount++;
    end
    jmpReq = 1'b1; jmpAddr = 8'h00;
    step();
    jmpReq = 1'b0;
    checkCount++;
    if (halted !== 1'b0 || romAddr !== 8'h00 || romEna !== 1'b1)
      $display("[TB] FAIL unhalt: got h%b addr %h ena %b expected h0 addr 00 ena 1", halted, romAddr, romEna);
    else passCount++;
    step();
`ifdef IFETCH_SKIP_NOP_EN
    checkCount++;
    if (insValid !== 1'b0 || romAddr !== 8'h01)
      $display("[TB] FAIL resume: got v%b addr %h expected v0 addr 01", insValid, romAddr);
    else passCount++;
`else
    checkCount++;
    if (insValid !== 1'b1 || insOpcode !== 8'h00 || insPc !== 8'h00)
      $display("[TB] FAIL resume: got v%b op %h pc %h expected v1 op 00 pc 00", insValid, insOpcode, insPc);
    else passCount++;
`endif
  endtask

  task automatic test_pc_wrap();
    rst1 = 1'b1; insReady1 = 1'b1; jmpReq1 = 1'b0; jmpAddr1 = 8'h00;
    step();
    checkCount++;
    if (romAddr1 !== 8'hFF || insValid1 !== 1'b0)
      $display("[TB] FAIL wrap_reset: got addr %h v%b expected addr FF v0", romAddr1, insValid1);
    else passCount++;
    rst1 = 1'b0;
    step();
    checkCount++;
    if (romAddr1 !== 8'h00 || romEna1 !== 1'b1 || insValid1 !== 1'b0)
      $display("[TB] FAIL wrap_arg_addr: got addr %h ena %b v%b expected addr 00 ena 1 v0", romAddr1, romEna1, insValid1);
    else passCount++;
    step();
    checkCount++;
    if (insValid1 !== 1'b1 || insOpcode1 !== 8'h11 || insOperand1 !== 8'h00 || insPc1 !== 8'hFF || insTwoByte1 !== 1'b1)
      $display("[TB] FAIL wrap_present: got v%b op %h arg %h pc %h tb %b expected v1 op 11 arg 00 pc FF tb 1",
               insValid1, insOpcode1, insOperand1, insPc1, insTwoByte1);
    else passCount++;
    step();
    checkCount++;
    if (romAddr1 !== 8'h01 || romEna1 !== 1'b1)
      $display("[TB] FAIL wrap_next: got addr %h ena %b expected addr 01 ena 1", romAddr1, romEna1);
    else passCount++;
    step();
    rst1 = 1'b1;
    step();
    checkCount++;
    if (romAddr1 !== 8'hFF || insValid1 !== 1'b0 || insOpcode1 !== 8'h00 || halted1 !== 1'b0)
      $display("[TB] FAIL rst_in_arg: got addr %h v%b op %h h%b expected addr FF v0 op 00 h0",
               romAddr1, insValid1, insOpcode1, halted1);
    else passCount++;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    mem[0]   = 8'h00; mem[1]  = 8'h11; mem[2]  = 8'h81; mem[9]   = 8'hA3;
    mem[10]  = 8'h0F; mem[14] = 8'hF0; mem[15] = 8'hB0; mem[129] = 8'h64;
    mem[255] = 8'h11;
    rst1 = 1'b1; insReady1 = 1'b1; jmpReq1 = 1'b0; jmpAddr1 = 8'h00;

    test_reset();
    test_first_fetch();
    test_hold();
    test_jump();
    test_halt();
    test_pc_wrap();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
